// File: rtl/vga_timing_gen.sv
// VGA raster generator: h/v counters feed a registered request stage, an EXT_LAT-deep
// alignment pipe, then registered sync/DE/RGB outputs; pixels come from upstream or built-in patterns.
module vga_timing_gen #(
  parameter int         H_ACTIVE  = 640,
  parameter int         H_FP      = 16,
  parameter int         H_SYNC    = 96,
  parameter int         H_BP      = 48,
  parameter int         V_ACTIVE  = 480,
  parameter int         V_FP      = 10,
  parameter int         V_SYNC    = 2,
  parameter int         V_BP      = 33,
  parameter bit         HS_POL    = 1'b0,
  parameter bit         VS_POL    = 1'b0,
  parameter int         EXT_LAT   = 2,
  parameter int         CHK_LOG2  = 4,
  parameter logic [7:0] SOLID_RGB = 8'hE0
) (
  input  logic       app_clk,
  input  logic       app_arst_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       pix_req,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  input  logic [7:0] pix_rgb,
  output logic       frame_start,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam int              BAR_W    = H_ACTIVE / 8;
  localparam int              BW_W     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BW_W-1:0] BAR_LAST = BW_W'(BAR_W - 1);

  // One raster position in flight; hs/vs here are "inside sync region", not pin levels.
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [1:0] mode;
    logic [9:0] x;
    logic [9:0] y;
  } stg_t;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0]    pat_q, pat_d;
  logic          origin;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!enable) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  // The mode in force for a frame is whatever pattern_sel shows at its origin,
  // including the origin pixel itself, so the bypass feeds the request stage directly.
  assign origin = (h_q == '0) && (v_q == '0);
  assign pat_d  = origin ? pattern_sel : pat_q;

  always_ff @(posedge app_clk or negedge app_arst_n) begin
    if (!app_arst_n) begin
      h_q   <= '0;
      v_q   <= '0;
      pat_q <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      pat_q <= pat_d;
    end
  end

  stg_t req_d;
  logic pix_req_d;

  always_comb begin
    req_d      = '0;
    req_d.de   = enable && (h_q < H_ACT_C) && (v_q < V_ACT_C);
    req_d.hs   = enable && (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    req_d.vs   = enable && (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    req_d.fs   = enable && origin;
    req_d.mode = pat_d;
    req_d.x    = 10'(h_q);
    req_d.y    = 10'(v_q);
    pix_req_d  = req_d.de && (pat_d == 2'd0);
  end

  // pipe_q[0] is the request stage; pipe_q[EXT_LAT] lines up with pix_rgb.
  stg_t pipe_q [EXT_LAT+1];
  logic pix_req_q;

  always_ff @(posedge app_clk or negedge app_arst_n) begin
    if (!app_arst_n) begin
      pix_req_q <= 1'b0;
      for (int i = 0; i <= EXT_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pix_req_q <= pix_req_d;
      pipe_q[0] <= req_d;
      for (int i = 1; i <= EXT_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign pix_req = pix_req_q;
  assign pix_x   = pipe_q[0].x;
  assign pix_y   = pipe_q[0].y;

  // Bar index tracked by counting visible pixels; restarts on x==0 so no divider is needed.
  logic [BW_W-1:0] bw_q, bw_d, cur_pos;
  logic [2:0]      bi_q, bi_d, cur_idx;
  logic            line_start;

  always_comb begin
    line_start = (pipe_q[EXT_LAT].x == 10'd0);
    cur_pos    = line_start ? '0 : bw_q;
    cur_idx    = line_start ? 3'd0 : bi_q;
    bw_d       = bw_q;
    bi_d       = bi_q;
    if (pipe_q[EXT_LAT].de) begin
      if (cur_pos == BAR_LAST) begin
        bw_d = '0;
        bi_d = cur_idx + 3'd1;
      end else begin
        bw_d = cur_pos + 1'b1;
        bi_d = cur_idx;
      end
    end
  end

  logic [7:0] bar_rgb, rgb_d;
  logic       chk_on;

  always_comb begin
    bar_rgb = {{3{cur_idx[2]}}, {3{cur_idx[1]}}, {2{cur_idx[0]}}};
    chk_on  = pipe_q[EXT_LAT].x[CHK_LOG2] ^ pipe_q[EXT_LAT].y[CHK_LOG2];
    rgb_d   = 8'h00;
    if (pipe_q[EXT_LAT].de) begin
      case (pipe_q[EXT_LAT].mode)
        2'd0:    rgb_d = pix_rgb;
        2'd1:    rgb_d = bar_rgb;
        2'd2:    rgb_d = chk_on ? 8'hFF : 8'h00;
        default: rgb_d = SOLID_RGB;
      endcase
    end
  end

  logic       de_q, hs_q, vs_q, fs_q;
  logic [7:0] rgb_q;

  always_ff @(posedge app_clk or negedge app_arst_n) begin
    if (!app_arst_n) begin
      bw_q  <= '0;
      bi_q  <= '0;
      de_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      fs_q  <= 1'b0;
      rgb_q <= 8'h00;
    end else begin
      bw_q  <= bw_d;
      bi_q  <= bi_d;
      de_q  <= pipe_q[EXT_LAT].de;
      hs_q  <= pipe_q[EXT_LAT].hs ? HS_POL : ~HS_POL;
      vs_q  <= pipe_q[EXT_LAT].vs ? VS_POL : ~VS_POL;
      fs_q  <= pipe_q[EXT_LAT].fs;
      rgb_q <= rgb_d;
    end
  end

  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign red         = rgb_q[7:5];
  assign green       = rgb_q[4:2];
  assign blue        = rgb_q[1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a small raster; expected outputs come from
// raster position arithmetic (position = cycles since start, minus pipeline latency).
module tb_vga_timing_gen;

  localparam int         HA = 32, HFP = 4, HSW = 6, HBP = 5;
  localparam int         VA = 12, VFP = 2, VSW = 3, VBP = 2;
  localparam int         HT = HA + HFP + HSW + HBP;
  localparam int         VT = VA + VFP + VSW + VBP;
  localparam int         FRAME = HT * VT;
  localparam int         LAT = 2;
  localparam int         CHK = 2;
  localparam logic [7:0] SOLID = 8'hE0;
  localparam bit         HS_POL = 1'b0;
  localparam bit         VS_POL = 1'b1;

  logic       app_clk = 1'b0;
  logic       app_arst_n;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       pix_req;
  logic [9:0] pix_x, pix_y;
  logic [7:0] pix_rgb;
  logic       frame_start, de, hsync, vsync;
  logic [2:0] red, green;
  logic [1:0] blue;

  always #5 app_clk = ~app_clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .EXT_LAT(LAT), .CHK_LOG2(CHK), .SOLID_RGB(SOLID)
  ) dut (
    .app_clk(app_clk), .app_arst_n(app_arst_n), .enable(enable), .pattern_sel(pattern_sel),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .de(de), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] bar_tab [8] = '{8'h00, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF};

  typedef struct {
    bit vld;
    int p;
    int mode;
  } ent_t;

  ent_t       hist[$];
  bit         rq_v[$];
  logic [9:0] rq_x[$];
  int run_k    = -1;
  int mode_cur = 0;
  int cyc      = 0;
  int last_fs  = -1;
  bit clean    = 1'b0;
  int de_cnt   = 0;
  int en_rise  = -1;

  function automatic logic [7:0] pat_rgb(int mode, int x, int y);
    case (mode)
      0:       return 8'(x);
      1:       return bar_tab[x / (HA / 8)];
      2:       return ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? 8'hFF : 8'h00;
      default: return SOLID;
    endcase
  endfunction

  function automatic logic [11:0] exp_out(ent_t e);
    int x, y;
    logic d, ihs, ivs;
    if (!e.vld) return {1'b0, ~HS_POL, ~VS_POL, 1'b0, 8'h00};
    x   = e.p % HT;
    y   = e.p / HT;
    d   = (x < HA) && (y < VA);
    ihs = (x >= HA + HFP) && (x < HA + HFP + HSW);
    ivs = (y >= VA + VFP) && (y < VA + VFP + VSW);
    return {d, ihs ? HS_POL : ~HS_POL, ivs ? VS_POL : ~VS_POL, (e.p == 0),
            d ? pat_rgb(e.mode, x, y) : 8'h00};
  endfunction

  task automatic flush_model();
    ent_t idle;
    idle.vld = 1'b0; idle.p = 0; idle.mode = 0;
    hist.delete();
    repeat (LAT + 2) hist.push_back(idle);
    run_k   = -1;
    clean   = 1'b0;
    en_rise = -1;
  endtask

  task automatic tick();
    bit   en_s, rst_s;
    int   sel_s, x, y;
    ent_t e;
    en_s  = enable;
    rst_s = app_arst_n;
    sel_s = int'(pattern_sel);
    @(posedge app_clk);
    #1;
    cyc++;
    e.vld = 1'b0; e.p = 0; e.mode = 0;
    if (!rst_s || !en_s) begin
      run_k   = -1;
      clean   = 1'b0;
      en_rise = -1;
    end else begin
      run_k = (run_k < 0) ? 0 : run_k + 1;
      e.p   = run_k % FRAME;
      if (e.p == 0) mode_cur = sel_s;
      e.vld  = 1'b1;
      e.mode = mode_cur;
    end
    hist.push_front(e);
    void'(hist.pop_back());
    chk("out", {de, hsync, vsync, frame_start, red, green, blue}, exp_out(hist[LAT+1]));
    if (e.vld) begin
      x = e.p % HT;
      y = e.p / HT;
      chk("req", {pix_req, pix_x, pix_y},
          {((x < HA) && (y < VA) && (e.mode == 0)), 10'(x), 10'(y)});
    end
    if (de) de_cnt++;
    if (frame_start) begin
      if (en_rise >= 0) begin
        chk("fs_latency", cyc - en_rise, LAT + 2);
        en_rise = -1;
      end
      if (clean && last_fs >= 0) begin
        chk("fs_period", cyc - last_fs, FRAME);
        chk("de_per_frame", de_cnt, HA * VA);
      end
      last_fs = cyc;
      de_cnt  = 0;
      clean   = 1'b1;
    end
    // Upstream source: answers each request exactly LAT cycles later, junk otherwise.
    rq_v.push_front(pix_req);
    rq_x.push_front(pix_x);
    if (rq_v.size() > LAT) begin
      pix_rgb = rq_v[LAT] ? rq_x[LAT][7:0] : 8'($urandom);
      void'(rq_v.pop_back());
      void'(rq_x.pop_back());
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_reset(input int hold);
    #3;
    app_arst_n = 1'b0;
    #1;
    chk("rst_out", {de, hsync, vsync, frame_start, red, green, blue},
        {1'b0, ~HS_POL, ~VS_POL, 1'b0, 8'h00});
    chk("rst_req", {pix_req, pix_x, pix_y}, 21'd0);
    flush_model();
    run(hold);
    app_arst_n = 1'b1;
    if (enable) en_rise = cyc;
  endtask

  initial begin
    app_arst_n  = 1'b1;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    pix_rgb     = 8'h00;
    flush_model();
    #1;
    app_arst_n = 1'b0;
    #1;
    chk("rst_out", {de, hsync, vsync, frame_start, red, green, blue},
        {1'b0, ~HS_POL, ~VS_POL, 1'b0, 8'h00});
    chk("rst_req", {pix_req, pix_x, pix_y}, 21'd0);
    run(3);
    app_arst_n  = 1'b1;
    enable      = 1'b1;
    pattern_sel = 2'd3;
    en_rise     = cyc;
    run(2 * FRAME + 50);

    // Bars, then switch to checker somewhere mid-frame.
    pattern_sel = 2'd1;
    run(FRAME + int'($urandom_range(100, FRAME - 100)));
    pattern_sel = 2'd2;
    run(2 * FRAME);

    pattern_sel = 2'd0;
    run(2 * FRAME);

    run(int'($urandom_range(5, HT - 5)));
    pulse_reset(2);
    run(FRAME + 100);

    enable = 1'b0;
    run(10);
    chk("idle_de", de, 1'b0);
    chk("idle_sync", {hsync, vsync}, {~HS_POL, ~VS_POL});
    chk("idle_rgb", {red, green, blue}, 8'h00);
    enable  = 1'b1;
    en_rise = cyc;
    run(FRAME + 50);

    for (int it = 0; it < 6; it++) begin
      pattern_sel = 2'($urandom_range(0, 3));
      run(int'($urandom_range(50, 2 * FRAME)));
      case ($urandom_range(0, 2))
        0: begin
          enable = 1'b0;
          run(int'($urandom_range(1, 20)));
          enable  = 1'b1;
          en_rise = cyc;
        end
        1: pulse_reset(int'($urandom_range(1, 3)));
        default: ;
      endcase
    end
    run(2 * FRAME + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
